// File: rtl/demultiplexer_1_to_8.sv
// ----------------------------------------------------------------------------
// demultiplexer_1_to_8
//
// Registered 1-to-8 lane-steering stage. A qualified input word is routed to
// the lane chosen by select_lines; every other lane is driven to zero. All
// outputs are registered, giving exactly one clock of latency and no
// combinational input-to-output path. Data is not held across idle cycles.
//
// Parameters:
//   DATA_W        width of the input word and of each output lane (>= 1)
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         synchronous active-low reset
//   in            data word to route
//   in_valid      qualifies in and select_lines this cycle
//   select_lines  destination lane index 0..7
//   output_lines  flattened lanes, lane k at [k*DATA_W +: DATA_W]
//   out_valid     registered copy of in_valid
//   lane_onehot   registered one-hot of the selected lane, zero when idle
// ----------------------------------------------------------------------------
module demultiplexer_1_to_8 #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in,
  input  logic                in_valid,
  input  logic [2:0]          select_lines,
  output logic [8*DATA_W-1:0] output_lines,
  output logic                out_valid,
  output logic [7:0]          lane_onehot
);

  logic [8*DATA_W-1:0] output_lines_d, output_lines_q;
  logic                out_valid_d,    out_valid_q;
  logic [7:0]          lane_onehot_d,  lane_onehot_q;

  // Lane enable decode: lane k is active only for a valid cycle that selects
  // it. The one-hot doubles as the per-lane data gate so the two can never
  // disagree.
  function automatic logic [7:0] lane_decode(input logic       vld,
                                             input logic [2:0] sel);
    logic [7:0] onehot;
    onehot = '0;
    for (int k = 0; k < 8; k++) begin
      onehot[k] = vld && (sel == 3'(k));
    end
    return onehot;
  endfunction

  always_comb begin
    output_lines_d = '0;
    lane_onehot_d  = lane_decode(in_valid, select_lines);
    out_valid_d    = in_valid;
    for (int k = 0; k < 8; k++) begin
      // Non-selected lanes stay zero rather than holding stale data.
      output_lines_d[k*DATA_W +: DATA_W] = lane_onehot_d[k] ? in : '0;
    end
  end

  // Output register stage: reset clears data as well as control so that a
  // reset cycle presents all-zero lanes downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_lines_q <= '0;
      out_valid_q    <= 1'b0;
      lane_onehot_q  <= 8'h00;
    end else begin
      output_lines_q <= output_lines_d;
      out_valid_q    <= out_valid_d;
      lane_onehot_q  <= lane_onehot_d;
    end
  end

  assign output_lines = output_lines_q;
  assign out_valid    = out_valid_q;
  assign lane_onehot  = lane_onehot_q;

endmodule

// File: tb/tb_demultiplexer_1_to_8.sv
// ----------------------------------------------------------------------------
// tb_demultiplexer_1_to_8
//
// Directed bench with two instances: DATA_W=1 (walking select, mid-stream
// reset, narrow 2-bit select driver) and DATA_W=8 (idle clearing, zero data,
// back-to-back routing). Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_demultiplexer_1_to_8;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in1, v1;
  logic [2:0]  sel1;
  logic [7:0]  out1;
  logic        ov1;
  logic [7:0]  oh1;

  logic [7:0]  in8;
  logic        v8;
  logic [2:0]  sel8;
  logic [63:0] out8;
  logic        ov8;
  logic [7:0]  oh8;

  logic [1:0]  sel_narrow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demultiplexer_1_to_8 #(.DATA_W(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in1),
    .in_valid     (v1),
    .select_lines (sel1),
    .output_lines (out1),
    .out_valid    (ov1),
    .lane_onehot  (oh1)
  );

  demultiplexer_1_to_8 #(.DATA_W(8)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in8),
    .in_valid     (v8),
    .select_lines (sel8),
    .output_lines (out8),
    .out_valid    (ov8),
    .lane_onehot  (oh8)
  );

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] walk_exp   [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] narrow_exp [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    rst_n = 1'b0;
    in1 = 1'b1; v1 = 1'b1; sel1 = 3'd5;
    in8 = 8'hFF; v8 = 1'b1; sel8 = 3'd5;
    sel_narrow = 2'd0;

    // Reset held two cycles with valid input present
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out1", 64'(out1), 64'h0);
      chk("rst_ov1",  64'(ov1),  64'h0);
      chk("rst_oh1",  64'(oh1),  64'h0);
      chk("rst_out8", out8,      64'h0);
      chk("rst_ov8",  64'(ov8),  64'h0);
      chk("rst_oh8",  64'(oh8),  64'h0);
    end
    rst_n = 1'b1;
    v8 = 1'b0;

    // Walking select, DATA_W=1
    for (int i = 0; i < 8; i++) begin
      in1 = 1'b1; v1 = 1'b1; sel1 = 3'(i);
      tick();
      chk($sformatf("walk_out_%0d", i), 64'(out1), 64'(walk_exp[i]));
      chk($sformatf("walk_oh_%0d", i),  64'(oh1),  64'(walk_exp[i]));
      chk($sformatf("walk_ov_%0d", i),  64'(ov1),  64'h1);
    end
    v1 = 1'b0;

    // Idle clears, DATA_W=8
    in8 = 8'hA5; sel8 = 3'd3; v8 = 1'b1;
    tick();
    chk("idle_valid_out8", out8,     64'h0000_0000_A500_0000);
    chk("idle_valid_oh8",  64'(oh8), 64'h08);
    chk("idle_valid_ov8",  64'(ov8), 64'h1);
    v8 = 1'b0;
    tick();
    chk("idle_out8", out8,     64'h0);
    chk("idle_oh8",  64'(oh8), 64'h0);
    chk("idle_ov8",  64'(ov8), 64'h0);
    chk("idle_out1", 64'(out1), 64'h0);
    chk("idle_ov1",  64'(ov1),  64'h0);

    // Zero data still flags the lane
    in8 = 8'h00; sel8 = 3'd6; v8 = 1'b1;
    tick();
    chk("zero_out8", out8,     64'h0);
    chk("zero_oh8",  64'(oh8), 64'h40);
    chk("zero_ov8",  64'(ov8), 64'h1);

    // Back-to-back valid cycles to the extreme lanes
    in8 = 8'h3C; sel8 = 3'd7;
    tick();
    chk("b2b_out8_l7", out8,     64'h3C00_0000_0000_0000);
    chk("b2b_oh8_l7",  64'(oh8), 64'h80);
    in8 = 8'hFF; sel8 = 3'd0;
    tick();
    chk("b2b_out8_l0", out8,     64'h0000_0000_0000_00FF);
    chk("b2b_oh8_l0",  64'(oh8), 64'h01);
    v8 = 1'b0;

    // Mid-stream reset, DATA_W=1
    in1 = 1'b1; sel1 = 3'd2; v1 = 1'b1;
    tick();
    chk("mid_pre_out1", 64'(out1), 64'h04);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out1", 64'(out1), 64'h0);
    chk("mid_rst_oh1",  64'(oh1),  64'h0);
    chk("mid_rst_ov1",  64'(ov1),  64'h0);
    rst_n = 1'b1;
    tick();
    chk("mid_post_out1", 64'(out1), 64'h04);
    chk("mid_post_oh1",  64'(oh1),  64'h04);
    chk("mid_post_ov1",  64'(ov1),  64'h1);

    // Narrow 2-bit select driver, zero-extended
    for (int j = 0; j < 4; j++) begin
      sel_narrow = 2'(j);
      sel1 = 3'(sel_narrow);
      in1 = 1'b1; v1 = 1'b1;
      tick();
      chk($sformatf("narrow_out_%0d", j), 64'(out1), 64'(narrow_exp[j]));
      chk($sformatf("narrow_hi_%0d", j),  64'(out1[7:4]), 64'h0);
    end
    v1 = 1'b0;
    tick();
    chk("final_idle_ov1", 64'(ov1), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
